// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: zero-latency hits, 4-word line refill on miss.
// Optional hit/miss counters are enabled by defining ICACHE_PERF_CNT_EN.
module icache_dm #(
  parameter int unsigned NUM_BLOCKS = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          proc_read,
  input  logic          proc_write,
  input  logic [29:0]   proc_addr,
  input  logic [31:0]   proc_wdata,
  output logic [31:0]   proc_rdata,
  output logic          proc_stall,
  output logic          mem_read,
  output logic          mem_write,
  output logic [27:0]   mem_addr,
  output logic [127:0]  mem_wdata,
  input  logic [127:0]  mem_rdata,
  input  logic          mem_ready
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]   hit_cnt,
  output logic [31:0]   miss_cnt
`endif
);

  localparam int unsigned IDX_W  = $clog2(NUM_BLOCKS);
  localparam int unsigned TAG_W  = 28 - IDX_W;
  localparam int unsigned LINE_W = 128;
  localparam int unsigned WORD_W = 32;

  typedef enum logic {IDLE, FETCH} state_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
  } line_addr_t;

  state_t     state_q, state_d;
  line_addr_t req_line;
  line_addr_t miss_line_q;
  logic [1:0] req_off;

  logic [NUM_BLOCKS-1:0] valid_q;
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [LINE_W-1:0]     data_q [NUM_BLOCKS];

  logic hit;
  logic miss_ld;
  logic fill_en;

  assign req_line = line_addr_t'(proc_addr[29:2]);
  assign req_off  = proc_addr[1:0];

  assign hit        = proc_read && valid_q[req_line.idx] && (tag_q[req_line.idx] == req_line.tag);
  assign proc_rdata = data_q[req_line.idx][{req_off, 5'd0} +: WORD_W];

  // Memory side: request driven purely from registered state.
  assign mem_read  = (state_q == FETCH);
  assign mem_addr  = 28'(miss_line_q);
  assign mem_write = 1'b0;
  assign mem_wdata = '0;

  logic unused_ok;
  assign unused_ok = ^{proc_write, proc_wdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    proc_stall = 1'b0;
    miss_ld    = 1'b0;
    fill_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (proc_read && !hit) begin
          proc_stall = 1'b1;
          miss_ld    = 1'b1;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        proc_stall = 1'b1;
        if (mem_ready) begin
          fill_en = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Miss address is held for the whole refill even if the PC is redirected.
  always_ff @(posedge clk) begin
    if (rst) begin
      miss_line_q <= '0;
    end else if (miss_ld) begin
      miss_line_q <= req_line;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[miss_line_q.idx] <= 1'b1;
    end
  end

  // Tag/data have no reset; a refill landing in a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (fill_en && !rst) begin
      tag_q[miss_line_q.idx]  <= miss_line_q.tag;
      data_q[miss_line_q.idx] <= mem_rdata;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if ((state_q == IDLE) && hit) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if (miss_ld) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: miss/refill timing, conflicts, redirect, reset mid-refill, idle.
// Counter checks compile in when ICACHE_PERF_CNT_EN is defined.
module tb_icache_dm;

  logic          clk;
  logic          rst;
  logic          proc_read;
  logic          proc_write;
  logic [29:0]   proc_addr;
  logic [31:0]   proc_wdata;
  logic [31:0]   proc_rdata;
  logic          proc_stall;
  logic          mem_read;
  logic          mem_write;
  logic [27:0]   mem_addr;
  logic [127:0]  mem_wdata;
  logic [127:0]  mem_rdata;
  logic          mem_ready;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]   hit_cnt;
  logic [31:0]   miss_cnt;
`endif

  int n_vec;
  int n_err;

  icache_dm #(.NUM_BLOCKS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Miss with refill returned two cycles after the request; ends in the first IDLE cycle.
  task automatic do_miss(input logic [29:0] addr, input logic [127:0] line,
                         input logic [27:0] exp_maddr, input logic [31:0] exp_word);
    @(negedge clk);
    proc_read = 1'b1;
    proc_addr = addr;
    mem_ready = 1'b0;
    #1;
    check_eq("miss_detect_stall", proc_stall, 1'b1);
    check_eq("miss_detect_mem_read", mem_read, 1'b0);
    @(negedge clk);
    #1;
    check_eq("fetch_mem_read", mem_read, 1'b1);
    check_eq("fetch_mem_addr", mem_addr, exp_maddr);
    @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = line;
    #1;
    check_eq("ready_cycle_stall", proc_stall, 1'b1);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check_eq("after_fill_stall", proc_stall, 1'b0);
    check_eq("after_fill_rdata", proc_rdata, exp_word);
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst        = 1'b1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    proc_addr  = '0;
    proc_wdata = '0;
    mem_rdata  = '0;
    mem_ready  = 1'b0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_stall", proc_stall, 1'b0);
    check_eq("rst_mem_read", mem_read, 1'b0);
    check_eq("rst_mem_addr", mem_addr, 28'h0);
    check_eq("rst_mem_write", mem_write, 1'b0);
    check_eq("rst_mem_wdata", mem_wdata, 128'h0);
`ifdef ICACHE_PERF_CNT_EN
    check_eq("rst_hit_cnt", hit_cnt, 32'd0);
    check_eq("rst_miss_cnt", miss_cnt, 32'd0);
`endif

    // Cold miss on 0x4, memory answers three cycles after detection.
    @(negedge clk);
    proc_read = 1'b1;
    proc_addr = 30'h4;
    #1;
    check_eq("cold_stall", proc_stall, 1'b1);
    check_eq("cold_T_mem_read", mem_read, 1'b0);
    @(negedge clk);
    #1;
    check_eq("cold_mem_read", mem_read, 1'b1);
    check_eq("cold_mem_addr", mem_addr, 28'h1);
    check_eq("cold_fetch_stall", proc_stall, 1'b1);
    @(negedge clk);
    #1;
    check_eq("cold_wait_mem_read", mem_read, 1'b1);
    @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = 128'h44444444_33333333_22222222_11111111;
    #1;
    check_eq("cold_M_mem_read", mem_read, 1'b1);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check_eq("cold_hit_stall", proc_stall, 1'b0);
    check_eq("cold_hit_mem_read", mem_read, 1'b0);
    check_eq("cold_hit_word0", proc_rdata, 32'h11111111);
    proc_addr = 30'h7;
    #1;
    check_eq("hit_word3_stall", proc_stall, 1'b0);
    check_eq("hit_word3_rdata", proc_rdata, 32'h44444444);

    // Conflict: 0x00 and 0x20 share index 0.
    do_miss(30'h00, 128'hA0000003_A0000002_A0000001_A0000000, 28'h0, 32'hA0000000);
    do_miss(30'h20, 128'hB0000003_B0000002_B0000001_B0000000, 28'h8, 32'hB0000000);
    do_miss(30'h00, 128'hA0000003_A0000002_A0000001_A0000000, 28'h0, 32'hA0000000);

    // Redirect to 0x40 while line 0x4 is being refilled.
    @(negedge clk);
    proc_addr = 30'h10;
    #1;
    check_eq("redir_detect_stall", proc_stall, 1'b1);
    @(negedge clk);
    proc_addr = 30'h40;
    #1;
    check_eq("redir_mem_read", mem_read, 1'b1);
    check_eq("redir_mem_addr_held", mem_addr, 28'h4);
    @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = 128'hC0000003_C0000002_C0000001_C0000000;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check_eq("redir_new_miss_stall", proc_stall, 1'b1);
    check_eq("redir_new_miss_mem_read", mem_read, 1'b0);
    @(negedge clk);
    #1;
    check_eq("redir_new_mem_addr", mem_addr, 28'h10);
    @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = 128'hD0000003_D0000002_D0000001_D0000000;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check_eq("redir_new_hit_stall", proc_stall, 1'b0);
    check_eq("redir_new_hit_rdata", proc_rdata, 32'hD0000000);
    proc_addr = 30'h10;
    #1;
    check_eq("redir_old_line_stall", proc_stall, 1'b0);
    check_eq("redir_old_line_rdata", proc_rdata, 32'hC0000000);
    proc_addr = 30'h13;
    #1;
    check_eq("redir_old_line_word3", proc_rdata, 32'hC0000003);

    // Reset in FETCH with mem_ready in the same cycle.
    @(negedge clk);
    proc_addr = 30'h8;
    #1;
    check_eq("rstmid_detect_stall", proc_stall, 1'b1);
    @(negedge clk);
    #1;
    check_eq("rstmid_mem_addr", mem_addr, 28'h2);
    @(negedge clk);
    rst       = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 128'hE0000003_E0000002_E0000001_E0000000;
    @(negedge clk);
    rst       = 1'b0;
    mem_ready = 1'b0;
    proc_read = 1'b0;
    #1;
    check_eq("rstmid_mem_read", mem_read, 1'b0);
    check_eq("rstmid_stall", proc_stall, 1'b0);
    proc_read = 1'b1;
    proc_addr = 30'h4;
    #1;
    check_eq("rstmid_valid_cleared", proc_stall, 1'b1);
    proc_read = 1'b0;
    do_miss(30'h8, 128'hE0000003_E0000002_E0000001_E0000000, 28'h2, 32'hE0000000);

    // Idle with random addresses and a stray mem_ready.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      proc_read = 1'b0;
      proc_addr = 30'($urandom);
      mem_ready = (i == 1);
      mem_rdata = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
      #1;
      check_eq("idle_stall", proc_stall, 1'b0);
      check_eq("idle_mem_read", mem_read, 1'b0);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check_eq("idle_no_fetch", mem_read, 1'b0);
    proc_read = 1'b1;
    proc_addr = 30'hA;
    #1;
    check_eq("idle_after_hit_stall", proc_stall, 1'b0);
    check_eq("idle_after_hit_rdata", proc_rdata, 32'hE0000002);

`ifdef ICACHE_PERF_CNT_EN
    // One miss then five hit cycles from a clean reset.
    @(negedge clk);
    rst       = 1'b1;
    proc_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("cnt_rst_hit", hit_cnt, 32'd0);
    check_eq("cnt_rst_miss", miss_cnt, 32'd0);
    do_miss(30'h4, 128'h44444444_33333333_22222222_11111111, 28'h1, 32'h11111111);
    repeat (4) @(negedge clk);
    @(negedge clk);
    proc_read = 1'b0;
    #1;
    check_eq("cnt_hit", hit_cnt, 32'd5);
    check_eq("cnt_miss", miss_cnt, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
